// File: rtl/fifo_reader.sv
// Prefetching reader that drains an upstream FIFO into a 2-entry output buffer with valid/ready handshake.
// Optional delivered-word counter on rd_count is built only when READER_COUNT_EN is defined.
//
// state | meaning
// EMPTY | no buffered word, out_valid low
// ONE   | head word in out_data
// TWO   | head word in out_data, next word in buf1
module fifo_reader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef READER_COUNT_EN
    output logic [15:0]       rd_count,
`endif
    output logic [DATA_W-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic              in_flight;
    logic              run;
    logic [DATA_W-1:0] buf1;
    logic [1:0]        occ;
    logic              pop;
    logic              cap;
    logic [2:0]        used;
    logic [2:0]        limit;

    assign occ   = state;
    assign pop   = out_valid & out_ready;
    assign cap   = in_flight;
    assign used  = {1'b0, occ} + {2'b00, in_flight};
    // A pop this cycle frees a slot in time for the word this read returns.
    assign limit = 3'd2 + {2'b00, pop};

    // run stays low through the cycle in which reset_n is released.
    assign fifo_rd_en = run & enable & ~fifo_empty & (used < limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run       <= 1'b0;
            in_flight <= 1'b0;
        end else begin
            run       <= 1'b1;
            in_flight <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            buf1      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (cap) begin
                        out_data  <= fifo_rdata;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (cap && pop) begin
                        out_data <= fifo_rdata;
                    end else if (cap) begin
                        buf1  <= fifo_rdata;
                        state <= TWO;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        out_data <= buf1;
                        if (cap) begin
                            buf1 <= fifo_rdata;
                        end else begin
                            state <= ONE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

`ifdef READER_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_count <= 16'd0;
        end else if (pop) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning width of FIFO read data and output stream data.
REQ-002 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port enable  input  1  permits issuing new FIFO reads when high.
REQ-005 SHALL provide port fifo_empty  input  1  read-side empty flag of upstream FIFO.
REQ-006 SHALL provide port fifo_rd_en  output  1  read strobe to upstream FIFO, one entry per high cycle.
REQ-007 SHALL provide port fifo_rdata  input  DATA_W  FIFO read data, valid exactly one cycle after fifo_rd_en.
REQ-008 SHALL provide port out_valid  output  1  out_data holds a valid word.
REQ-009 SHALL provide port out_ready  input  1  downstream accepts word when high with out_valid.
REQ-010 SHALL provide port out_data  output  DATA_W  head word of output buffer.
REQ-011 SHALL provide port rd_count  output  16  number of words delivered downstream (present only with READER_COUNT_EN).

Function
REQ-012 SHALL hold a 2-entry output buffer with FSM states EMPTY (0 words), ONE (1), TWO (2); out_valid SHALL be high in ONE and TWO, registered.
REQ-013 SHALL track one in-flight flag, set the cycle after fifo_rd_en is high, marking fifo_rdata capture that cycle.
REQ-014 SHALL drive fifo_rd_en = enable & !fifo_empty & (occupancy + in-flight + 0 < 2, counting a same-cycle downstream pop as freeing a slot); never overrun the buffer.
REQ-015 SHALL capture fifo_rdata into the buffer on the rising edge ending every in-flight cycle; never drop an in-flight word, including when enable falls.
REQ-016 SHALL transfer a word when out_valid & out_ready; out_data SHALL then advance to the next buffered word in order.
REQ-017 Transitions: EMPTY->ONE on capture; ONE->TWO on capture without pop; ONE->EMPTY on pop without capture; TWO->ONE on pop; capture+pop simultaneously SHALL keep state unchanged.
REQ-018 First-word latency SHALL be 2 cycles: fifo_empty low at cycle N (buffer empty, enable high) -> fifo_rd_en at N, capture at end of N+1, out_valid at N+2.
REQ-019 With out_ready held high and fifo_empty held low, throughput SHALL be one word per cycle after the first.
REQ-020 out_data SHALL remain stable while out_valid & !out_ready.
REQ-021 Word order at out_data SHALL equal FIFO read order; no duplication.

Reset
REQ-022 On reset_n low, SHALL asynchronously force state EMPTY, in-flight 0, out_valid 0, out_data 0, rd_count 0; fifo_rd_en SHALL be 0 while reset_n is low.
REQ-023 Reset mid-operation SHALL discard buffered and in-flight words; first read after release SHALL follow REQ-018.
REQ-024 Release of reset_n SHALL be synchronised externally; block SHALL not issue reads in the cycle reset_n rises.

Configuration
REQ-025 Macro READER_COUNT_EN: when defined, rd_count SHALL exist and increment by 1 per downstream transfer, wrapping 0xFFFF->0x0000.
REQ-026 Without READER_COUNT_EN, rd_count port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 Reset, fifo_empty=0, enable=1, out_ready=1, FIFO data 0x11,0x22,0x33 -> out_valid at cycle 2, out_data 0x11,0x22,0x33 on consecutive cycles.
REQ-028 out_ready=0, FIFO non-empty -> exactly 2 fifo_rd_en pulses, state TWO, out_data stays 0x11; raise out_ready -> 0x11 then 0x22, reads resume.
REQ-029 enable drops the cycle after a fifo_rd_en -> in-flight word still captured and delivered; no further fifo_rd_en.
REQ-030 fifo_empty toggling every cycle with out_ready=1 -> no extra reads, output order matches FIFO order.
REQ-031 Assert reset_n low in state TWO -> out_valid 0 immediately, rd_count 0; post-release first word latency 2 cycles.
REQ-032 READER_COUNT_EN defined, 65537 transfers -> rd_count = 0x0001.
